controlador_config_pantalla: RTL and testbench
==============================================

Name: controlador_config_pantalla

Overview:
- Sequences the clock screen's configuration user interface.
- Converts debounced push-button pulses into the config_mode, cursor_location and formato_hora signals that drive the screen, plus one-cycle inc/dec requests to the RTC.
- Generates the cursor blink enable.
- Owns the RING alarm display lifetime: RTC timer_end event → ring_active for the screen → ring_ack back to the RTC.

Parameters:
- CLK_HZ, 100000000, clock cycles per second; sets the ring-timeout seconds prescaler.
- BLINK_HALF, 25000000, cycles per half blink period (2 Hz blink at 100 MHz).
- RING_TIMEOUT_S, 10, seconds the RING indication stays up without a button press.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_mode  in  1  debounced 1-cycle pulse; cycles the configuration mode
- btn_right  in  1  debounced 1-cycle pulse; cursor to next field
- btn_left  in  1  debounced 1-cycle pulse; cursor to previous field
- btn_up  in  1  debounced 1-cycle pulse; increment field under cursor
- btn_down  in  1  debounced 1-cycle pulse; decrement field under cursor
- btn_format  in  1  debounced 1-cycle pulse; toggle 12/24 h format
- timer_end  in  1  level from RTC; timer finished
- config_mode  out  2  00 normal, 01 set time, 10 set date, 11 set timer
- cursor_location  out  2  field index 0..2 (HH/DD, MM/MES, SS/YEAR)
- cursor_blink  out  1  1 = draw cursor highlight this phase
- inc_pulse  out  1  1-cycle increment request to RTC
- dec_pulse  out  1  1-cycle decrement request to RTC
- formato_hora  out  1  0 = 24 h, 1 = 12 h (AM/PM shown)
- ring_active  out  1  show RING box/text
- ring_ack  out  1  1-cycle pulse to RTC clearing timer_end

Behaviour:
- Reset values: all outputs 0, FSM in NORMAL, all counters 0, registered previous value of timer_end = 0.
- Registering and latency: all outputs are registered. A button pulse in cycle N updates the outputs in cycle N+1. inc_pulse and dec_pulse are high for exactly cycle N+1.
- Button priority, when several pulses arrive in one cycle: mode > format > right > left > up > down. Only the winning button is acted on; the others are dropped.
- FSM transitions on btn_mode: NORMAL(00) → HORA(01) → FECHA(10) → TIMER(11) → NORMAL.
  - Entering any state sets cursor_location = 0.
- In NORMAL:
  - right, left, up, down and format are ignored.
  - cursor_blink = 0 and the blink counter is held at 0.
- In a configuration state:
  - right: cursor 0→1→2→0.
  - left: cursor 0→2→1→0.
  - cursor_location = 3 never occurs.
  - up → inc_pulse; down → dec_pulse.
  - The RTC decodes the field from config_mode and cursor_location; both are stable during the pulse.
- btn_format toggles formato_hora only in HORA; it is ignored elsewhere. formato_hora is held across all mode changes.
- Blink:
  - In a configuration state, the counter counts 0..BLINK_HALF-1 and toggles cursor_blink on wrap.
  - Any cursor move, mode change or inc/dec restarts the counter at 0 with cursor_blink = 1, so the cursor is visible immediately.
- Ring detection: a rising edge of timer_end (current 1, registered previous 0) sets ring_active = 1 the next cycle. It also restarts the seconds prescaler (0..CLK_HZ-1) and the seconds counter.
- Ring clearing:
  - ring_active clears when the seconds counter reaches RING_TIMEOUT_S, or on any button pulse while ring_active = 1.
  - The clearing button is consumed: no mode, cursor, format or inc/dec effect.
  - Clearing drives ring_ack = 1 for one cycle, in the same cycle ring_active falls.
- Ring boundary cases:
  - A rising edge while already active restarts the timeout, with no ack.
  - A rising edge and a button pulse in the same cycle: the edge wins and the button is dropped.
  - timer_end staying high after ack produces no new edge.
- The ring function runs independently of the FSM state. The FSM state and cursor are untouched by ring events.
- Reset asserted mid-operation (during ring, blink or any configuration state) returns to the reset values on the next clock edge.

Test Plan:
- Mode cycling: CLK_HZ=100, BLINK_HALF=10, RING_TIMEOUT_S=2. After reset, pulse btn_mode ×4 → config_mode 01, 10, 11, 00, each one cycle after its pulse; cursor_location = 0 throughout.
- Cursor and edit: in config_mode 01, pulse right ×3 → cursor 1, 2, 0. Pulse left → 2. Pulse up → inc_pulse high exactly one cycle with cursor_location = 2. Pulse down → dec_pulse one cycle. Same pulses in NORMAL → no output change.
- Blink: in config mode → cursor_blink = 1, toggles every 10 cycles. A right pulse mid-phase → cursor_blink = 1 next cycle, next toggle 10 cycles later. Return to NORMAL → cursor_blink = 0.
- Format: btn_format in HORA → formato_hora 0→1. btn_format in FECHA → no change. Simultaneous btn_mode + btn_format in HORA → only the mode advances.
- Ring timeout: raise timer_end → ring_active = 1 next cycle. After 200 cycles, ring_active = 0 with a single-cycle ring_ack. timer_end held high afterwards → no re-trigger.
- Ring by button: raise timer_end, then pulse btn_mode during ring → ring_active drops, ring_ack pulses, config_mode unchanged. Assert reset during ring → ring_active = 0 and ring_ack = 0 next cycle.

Source files
------------

// File: rtl/controlador_config_pantalla.sv
// rtl/controlador_config_pantalla.sv - clock screen configuration UI sequencer
//
// Turns debounced push-button pulses into the screen configuration state
// (config_mode, cursor_location, formato_hora). It also issues one-cycle
// inc/dec requests to the RTC, generates the cursor blink and owns the RING
// alarm indication lifetime.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   btn_mode            cycle NORMAL -> HORA -> FECHA -> TIMER -> NORMAL
//   btn_format          toggle 12/24 h (HORA only)
//   btn_right/btn_left  move cursor over fields 0..2
//   btn_up/btn_down     request increment/decrement of field under cursor
//   timer_end           RTC timer finished (level)
//   config_mode         00 normal, 01 time, 10 date, 11 timer
//   cursor_location     field index 0..2
//   cursor_blink        cursor highlight phase
//   inc_pulse/dec_pulse one-cycle edit requests to RTC
//   formato_hora        0 = 24 h, 1 = 12 h
//   ring_active         show RING indication
//   ring_ack            one-cycle pulse clearing timer_end in the RTC

module controlador_config_pantalla #(
    parameter int CLK_HZ         = 100000000,
    parameter int BLINK_HALF     = 25000000,
    parameter int RING_TIMEOUT_S = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_format,
    input  logic       timer_end,
    output logic [1:0] config_mode,
    output logic [1:0] cursor_location,
    output logic       cursor_blink,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       formato_hora,
    output logic       ring_active,
    output logic       ring_ack
);

    localparam logic [1:0] ST_NORMAL = 2'b00;
    localparam logic [1:0] ST_HORA   = 2'b01;
    localparam logic [1:0] ST_FECHA  = 2'b10;
    localparam logic [1:0] ST_TIMER  = 2'b11;

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int SW = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);
    localparam logic [SW-1:0] SEC_LAST  = SW'(RING_TIMEOUT_S - 1);

    logic [1:0]    mode_q, mode_d;
    logic [1:0]    cursor_q, cursor_d;
    logic          blink_q, blink_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          inc_q, inc_d;
    logic          dec_q, dec_d;
    logic          fmt_q, fmt_d;
    logic          ring_q, ring_d;
    logic          ack_q, ack_d;
    logic          te_prev_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] sec_q, sec_d;

    logic te_rise;
    logic any_btn;
    logic btn_live;
    logic restart_blink;

    assign te_rise = timer_end & ~te_prev_q;
    assign any_btn = btn_mode | btn_right | btn_left | btn_up | btn_down | btn_format;

    always_comb begin
        mode_d        = mode_q;
        cursor_d      = cursor_q;
        blink_d       = blink_q;
        blink_cnt_d   = blink_cnt_q;
        inc_d         = 1'b0;
        dec_d         = 1'b0;
        fmt_d         = fmt_q;
        ring_d        = ring_q;
        ack_d         = 1'b0;
        presc_d       = presc_q;
        sec_d         = sec_q;
        btn_live      = 1'b0;
        restart_blink = 1'b0;

        // Ring handling. A button only reaches the UI when no rising edge is
        // arriving and no RING indication is up; otherwise it is swallowed.
        if (te_rise) begin
            ring_d  = 1'b1;
            presc_d = '0;
            sec_d   = '0;
        end else if (ring_q) begin
            if (any_btn) begin
                ring_d  = 1'b0;
                ack_d   = 1'b1;
                presc_d = '0;
                sec_d   = '0;
            end else if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                // Last second completes: the seconds count reaches the timeout.
                if (sec_q == SEC_LAST) begin
                    ring_d = 1'b0;
                    ack_d  = 1'b1;
                    sec_d  = '0;
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else begin
            btn_live = 1'b1;
        end

        // Free-running blink; overridden below when an event restarts it.
        if (mode_q == ST_NORMAL) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        // Priority chain: mode > format > right > left > up > down.
        if (btn_live) begin
            if (btn_mode) begin
                mode_d        = mode_q + 2'd1;
                cursor_d      = 2'd0;
                restart_blink = 1'b1;
            end else if (btn_format) begin
                if (mode_q == ST_HORA) begin
                    fmt_d = ~fmt_q;
                end
            end else if (mode_q != ST_NORMAL) begin
                if (btn_right) begin
                    cursor_d      = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
                    restart_blink = 1'b1;
                end else if (btn_left) begin
                    cursor_d      = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
                    restart_blink = 1'b1;
                end else if (btn_up) begin
                    inc_d         = 1'b1;
                    restart_blink = 1'b1;
                end else if (btn_down) begin
                    dec_d         = 1'b1;
                    restart_blink = 1'b1;
                end
            end
        end

        // Show the cursor immediately after any edit; NORMAL never blinks.
        if (restart_blink) begin
            blink_cnt_d = '0;
            blink_d     = (mode_d != ST_NORMAL);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q      <= ST_NORMAL;
            cursor_q    <= 2'd0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            fmt_q       <= 1'b0;
            ring_q      <= 1'b0;
            ack_q       <= 1'b0;
            te_prev_q   <= 1'b0;
            presc_q     <= '0;
            sec_q       <= '0;
        end else begin
            mode_q      <= mode_d;
            cursor_q    <= cursor_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            fmt_q       <= fmt_d;
            ring_q      <= ring_d;
            ack_q       <= ack_d;
            te_prev_q   <= timer_end;
            presc_q     <= presc_d;
            sec_q       <= sec_d;
        end
    end

    assign config_mode     = mode_q;
    assign cursor_location = cursor_q;
    assign cursor_blink    = blink_q;
    assign inc_pulse       = inc_q;
    assign dec_pulse       = dec_q;
    assign formato_hora    = fmt_q;
    assign ring_active     = ring_q;
    assign ring_ack        = ack_q;

    // ST_FECHA and ST_TIMER are reached by the mode increment; named for readers.
    logic unused_states;
    assign unused_states = ^{ST_FECHA, ST_TIMER};

endmodule

// File: tb/tb_controlador_config_pantalla.sv
// tb/tb_controlador_config_pantalla.sv - scoreboard bench for controlador_config_pantalla

module tb_controlador_config_pantalla;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_right, btn_left, btn_up, btn_down, btn_format;
    logic       timer_end;
    logic [1:0] config_mode, cursor_location;
    logic       cursor_blink, inc_pulse, dec_pulse, formato_hora, ring_active, ring_ack;

    controlador_config_pantalla #(
        .CLK_HZ(100),
        .BLINK_HALF(10),
        .RING_TIMEOUT_S(2)
    ) dut (
        .clock(clk),
        .reset(reset),
        .btn_mode(btn_mode),
        .btn_right(btn_right),
        .btn_left(btn_left),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_format(btn_format),
        .timer_end(timer_end),
        .config_mode(config_mode),
        .cursor_location(cursor_location),
        .cursor_blink(cursor_blink),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .formato_hora(formato_hora),
        .ring_active(ring_active),
        .ring_ack(ring_ack)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] M_MODE = 10'b11_00_000000;
    localparam logic [9:0] M_CUR  = 10'b00_11_000000;
    localparam logic [9:0] M_BLK  = 10'b00_00_100000;
    localparam logic [9:0] M_FMT  = 10'b00_00_000100;
    localparam logic [9:0] M_RING = 10'b00_00_000010;
    localparam logic [9:0] M_ACK  = 10'b00_00_000001;
    localparam logic [9:0] M_ALL  = 10'h3FF;

    // {mode, format, right, left, up, down}
    localparam logic [5:0] B_MODE = 6'b100000;
    localparam logic [5:0] B_FMT  = 6'b010000;
    localparam logic [5:0] B_R    = 6'b001000;
    localparam logic [5:0] B_L    = 6'b000100;
    localparam logic [5:0] B_U    = 6'b000010;
    localparam logic [5:0] B_D    = 6'b000001;

    typedef struct {
        int         cyc;
        string      nm;
        logic [9:0] val;
        logic [9:0] msk;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic done = 1'b0;
    logic left_done = 1'b0;
    exp_t mon_e;
    logic [9:0] dout;

    assign dout = {config_mode, cursor_location, cursor_blink, inc_pulse,
                   dec_pulse, formato_hora, ring_active, ring_ack};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] ov(logic [1:0] md, logic [1:0] cu, logic bl,
                                      logic inc, logic dec, logic fm, logic rg, logic ak);
        return {md, cu, bl, inc, dec, fm, rg, ak};
    endfunction

    task automatic push(input int d, input string nm, input logic [9:0] v, input logic [9:0] m);
        exp_t e;
        int   pos;
        e.cyc = cyc + d;
        e.nm  = nm;
        e.val = v;
        e.msk = m;
        pos = sb.size();
        while (pos > 0 && sb[pos-1].cyc > e.cyc) pos--;
        sb.insert(pos, e);
    endtask

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.cyc < cyc) begin
                failures++;
                $display("FAIL %s: slot at cycle %0d missed (now %0d)", mon_e.nm, mon_e.cyc, cyc);
            end else if ((dout & mon_e.msk) !== (mon_e.val & mon_e.msk)) begin
                failures++;
                $display("FAIL %s: cycle %0d got=%b want=%b mask=%b",
                         mon_e.nm, cyc, dout, mon_e.val, mon_e.msk);
            end
        end
        if (done && !left_done) begin
            left_done = 1'b1;
            checks++;
            if (sb.size() != 0) begin
                failures++;
                $display("FAIL leftover: got=%0d pending expectations want=0", sb.size());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic pulse(input logic [5:0] b);
        {btn_mode, btn_format, btn_right, btn_left, btn_up, btn_down} = b;
        step();
        {btn_mode, btn_format, btn_right, btn_left, btn_up, btn_down} = 6'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1;
        timer_end = 1'b0;
        {btn_mode, btn_format, btn_right, btn_left, btn_up, btn_down} = 6'b0;
        step();
        step();
        push(0, "reset_vals", 10'b0, M_ALL);
        step();
        reset = 1'b0;
        step();

        // Mode cycling
        for (int i = 0; i < 4; i++) begin
            push(1, "mode_cycle", ov(2'(i + 1), 2'd0, (i < 3), 0, 0, 0, 0, 0),
                 M_MODE | M_CUR | M_BLK);
            pulse(B_MODE);
        end

        // NORMAL ignores everything but mode
        push(1, "norm_right", 10'b0, M_ALL); pulse(B_R);
        push(1, "norm_left",  10'b0, M_ALL); pulse(B_L);
        push(1, "norm_up",    10'b0, M_ALL); pulse(B_U);
        push(1, "norm_down",  10'b0, M_ALL); pulse(B_D);
        push(1, "norm_fmt",   10'b0, M_ALL); pulse(B_FMT);

        // Cursor and edit in HORA
        push(1, "enter_hora", ov(2'd1, 2'd0, 1, 0, 0, 0, 0, 0), M_ALL); pulse(B_MODE);
        push(1, "right1", ov(2'd1, 2'd1, 1, 0, 0, 0, 0, 0), M_ALL); pulse(B_R);
        push(1, "right2", ov(2'd1, 2'd2, 1, 0, 0, 0, 0, 0), M_ALL); pulse(B_R);
        push(1, "right0", ov(2'd1, 2'd0, 1, 0, 0, 0, 0, 0), M_ALL); pulse(B_R);
        push(1, "left2",  ov(2'd1, 2'd2, 1, 0, 0, 0, 0, 0), M_ALL); pulse(B_L);
        push(1, "up_inc", ov(2'd1, 2'd2, 1, 1, 0, 0, 0, 0), M_ALL);
        push(2, "up_end", ov(2'd1, 2'd2, 1, 0, 0, 0, 0, 0), M_ALL); pulse(B_U);
        push(1, "dn_dec", ov(2'd1, 2'd2, 1, 0, 1, 0, 0, 0), M_ALL);
        push(2, "dn_end", ov(2'd1, 2'd2, 1, 0, 0, 0, 0, 0), M_ALL); pulse(B_D);
        push(1, "up_down_prio", ov(2'd1, 2'd2, 1, 1, 0, 0, 0, 0), M_ALL); pulse(B_U | B_D);

        // Blink phase and restart
        base = cyc;
        push(1,  "blk_move", ov(2'd1, 2'd0, 1, 0, 0, 0, 0, 0), M_CUR | M_BLK);
        push(10, "blk_hi",   ov(0, 0, 1, 0, 0, 0, 0, 0), M_BLK);
        push(11, "blk_lo",   ov(0, 0, 0, 0, 0, 0, 0, 0), M_BLK);
        push(20, "blk_lo2",  ov(0, 0, 0, 0, 0, 0, 0, 0), M_BLK);
        push(21, "blk_hi2",  ov(0, 0, 1, 0, 0, 0, 0, 0), M_BLK);
        pulse(B_R);
        wait_until(base + 25);
        push(1,  "blk_restart", ov(2'd1, 2'd1, 1, 0, 0, 0, 0, 0), M_CUR | M_BLK);
        push(10, "blk_rs_hi",   ov(0, 0, 1, 0, 0, 0, 0, 0), M_BLK);
        push(11, "blk_rs_lo",   ov(0, 0, 0, 0, 0, 0, 0, 0), M_BLK);
        pulse(B_R);
        wait_until(base + 40);

        // Format
        push(1, "fmt_hora",  ov(2'd1, 0, 0, 0, 0, 1, 0, 0), M_MODE | M_FMT); pulse(B_FMT);
        push(1, "mode_fmt",  ov(2'd2, 2'd0, 1, 0, 0, 1, 0, 0), M_MODE | M_CUR | M_BLK | M_FMT);
        pulse(B_MODE | B_FMT);
        push(1, "fmt_fecha", ov(2'd2, 0, 0, 0, 0, 1, 0, 0), M_MODE | M_FMT); pulse(B_FMT);
        push(1, "to_timer",  ov(2'd3, 2'd0, 1, 0, 0, 1, 0, 0), M_ALL); pulse(B_MODE);
        push(1, "to_normal", ov(2'd0, 2'd0, 0, 0, 0, 1, 0, 0), M_ALL); pulse(B_MODE);

        // Ring timeout: 200 cycles at CLK_HZ=100, RING_TIMEOUT_S=2
        base = cyc;
        timer_end = 1'b1;
        push(1,   "ring_set",  ov(0, 0, 0, 0, 0, 0, 1, 0), M_MODE | M_RING | M_ACK);
        push(200, "ring_hold", ov(0, 0, 0, 0, 0, 0, 1, 0), M_RING | M_ACK);
        push(201, "ring_tmo",  ov(0, 0, 0, 0, 0, 0, 0, 1), M_MODE | M_RING | M_ACK);
        push(202, "ack_1cyc",  ov(0, 0, 0, 0, 0, 0, 0, 0), M_RING | M_ACK);
        push(260, "no_retrig", ov(0, 0, 0, 0, 0, 0, 0, 0), M_RING | M_ACK);
        wait_until(base + 262);
        timer_end = 1'b0;
        step();

        // Ring cleared by button
        base = cyc;
        timer_end = 1'b1;
        push(1, "ring_set2", ov(0, 0, 0, 0, 0, 0, 1, 0), M_RING | M_ACK);
        wait_until(base + 5);
        push(1, "ring_btn_clr", ov(2'd0, 2'd0, 0, 0, 0, 1, 0, 1), M_ALL);
        push(2, "ring_btn_ack", ov(2'd0, 2'd0, 0, 0, 0, 1, 0, 0), M_ALL);
        pulse(B_MODE);
        timer_end = 1'b0;
        step();

        // Edge and button in the same cycle: edge wins
        timer_end = 1'b1;
        btn_mode = 1'b1;
        push(1, "edge_wins", ov(2'd0, 2'd0, 0, 0, 0, 1, 1, 0), M_ALL);
        step();
        btn_mode = 1'b0;
        step();
        step();

        // Reset during ring
        reset = 1'b1;
        timer_end = 1'b0;
        push(1, "rst_ring", 10'b0, M_ALL);
        step();
        reset = 1'b0;
        push(1, "post_rst", 10'b0, M_ALL);
        step();
        step();

        done = 1'b1;
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
